// File: rtl/mips_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Resolves memory-wait, taken-branch, load-use and ID-jump events into
// pipeline-register enables/flushes, and keeps saturating performance
// counters plus a sticky data-memory timeout flag.
module mips_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_data1_i,
    input  logic             id_use_data2_i,
    input  logic             id_is_store_i,
    input  logic             id_jump_i,
    input  logic [4:0]       ex_dst_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memread_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_flush_o,
    output logic             exmem_en_o,
    output logic             memwb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    // Wait count at which the access is abandoned instead of stalling again.
    localparam logic [7:0]       LP_TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wcnt;
    logic [7:0]       w_wcnt_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_timeout;
    logic w_mem_stall;
    logic w_load_use;

    // Loads forward too late for an ID consumer; a store's rt is forwarded
    // later in the pipe, so it never needs the bubble.
    assign w_load_use = ex_memread_i & ex_regwrite_i & (ex_dst_i != 5'd0) &
                        ((id_use_data1_i & (id_rs_i == ex_dst_i)) |
                         (id_use_data2_i & ~id_is_store_i & (id_rt_i == ex_dst_i)));

    assign w_timeout   = (r_state == MEMWAIT) && (r_wcnt == LP_TMO_LAST);
    assign w_mem_stall = mem_req_i & ~mem_ready_i & ~w_timeout;

    // Prioritised event decode into pipeline enables and flushes.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if-chain leaves a signal unassigned and infers a latch.
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_en_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_en_o    = 1'b1;
        memwb_flush_o = 1'b0;
        if (rst) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            memwb_flush_o = 1'b1;
        end else if (w_mem_stall) begin
            // Whole front of the pipe frozen; redirects wait for release.
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_flush_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            // Squashes the ID instruction, so load-use and jump are moot.
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (w_load_use) begin
            // Also holds back a jr/jalr whose rs is still being loaded.
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else if (id_jump_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    // Next state of the memory-wait FSM and its wait counter.
    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_mem_err_nxt = r_mem_err;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEMWAIT;
                    w_wcnt_nxt  = 8'd1;
                end else begin
                    w_wcnt_nxt = 8'd0;
                end
            end
            MEMWAIT: begin
                if (w_mem_stall) begin
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end else begin
                    // Ready or aborted: either way the pipe is released now.
                    w_state_nxt = RUN;
                    w_wcnt_nxt  = 8'd0;
                    if (w_timeout && !mem_ready_i) begin
                        w_mem_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wcnt_nxt  = 8'd0;
            end
        endcase
    end

    // State, error flag and saturating performance counters.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            r_state     <= RUN;
            r_wcnt      <= 8'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_mem_err_nxt;
            if (!pc_en_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
            end
            if (ifid_flush_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign mem_err_o   = r_mem_err;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Self-checking bench for mips_pipe_ctrl. Two instances share stimulus:
// one with default parameters, one with MEM_TIMEOUT=4 / CNT_W=4 for the
// timeout and saturation cases. A cycle-level reference model tracks
// wait length, error flag and counters for both.
module tb_mips_pipe_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use1;
        logic       use2;
        logic       store;
        logic       jump;
        logic [4:0] dst;
        logic       regwr;
        logic       memrd;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_use1, id_use2, id_store, id_jump;
    logic       ex_regwr, ex_memrd, ex_br, mem_req, mem_rdy;

    logic        pc_en0, ifid_en0, ifid_fl0, idex_en0, idex_fl0, exmem_en0, memwb_fl0, err0;
    logic [31:0] stall0, flush0;
    logic        pc_en1, ifid_en1, ifid_fl1, idex_en1, idex_fl1, exmem_en1, memwb_fl1, err1;
    logic [3:0]  stall1, flush1;

    mips_pipe_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_data1_i(id_use1), .id_use_data2_i(id_use2),
        .id_is_store_i(id_store), .id_jump_i(id_jump),
        .ex_dst_i(ex_dst), .ex_regwrite_i(ex_regwr), .ex_memread_i(ex_memrd),
        .ex_branch_taken_i(ex_br), .mem_req_i(mem_req), .mem_ready_i(mem_rdy),
        .pc_en_o(pc_en0), .ifid_en_o(ifid_en0), .ifid_flush_o(ifid_fl0),
        .idex_en_o(idex_en0), .idex_flush_o(idex_fl0), .exmem_en_o(exmem_en0),
        .memwb_flush_o(memwb_fl0), .stall_cnt_o(stall0), .flush_cnt_o(flush0),
        .mem_err_o(err0)
    );

    mips_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_data1_i(id_use1), .id_use_data2_i(id_use2),
        .id_is_store_i(id_store), .id_jump_i(id_jump),
        .ex_dst_i(ex_dst), .ex_regwrite_i(ex_regwr), .ex_memread_i(ex_memrd),
        .ex_branch_taken_i(ex_br), .mem_req_i(mem_req), .mem_ready_i(mem_rdy),
        .pc_en_o(pc_en1), .ifid_en_o(ifid_en1), .ifid_flush_o(ifid_fl1),
        .idex_en_o(idex_en1), .idex_flush_o(idex_fl1), .exmem_en_o(exmem_en1),
        .memwb_flush_o(memwb_fl1), .stall_cnt_o(stall1), .flush_cnt_o(flush1),
        .mem_err_o(err1)
    );

    // Control vectors ordered {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}.
    logic [6:0]  ctrl0, ctrl1;
    logic [87:0] obs;
    assign ctrl0 = {pc_en0, ifid_en0, ifid_fl0, idex_en0, idex_fl0, exmem_en0, memwb_fl0};
    assign ctrl1 = {pc_en1, ifid_en1, ifid_fl1, idex_en1, idex_fl1, exmem_en1, memwb_fl1};
    assign obs   = {ctrl0, err0, stall0, flush0, ctrl1, err1, stall1, flush1};

    localparam logic [6:0] C_IDLE   = 7'b1101010;
    localparam logic [6:0] C_FROZEN = 7'b0000001;
    localparam logic [6:0] C_JUMP   = 7'b1111010;

    // Reference model state, index 0 = default instance, 1 = small instance.
    int     tmo_lim [2] = '{16, 4};
    longint cnt_max [2] = '{64'hFFFF_FFFF, 64'hF};
    int     m_wait  [2];
    bit     m_err   [2];
    longint m_stall [2];
    longint m_flush [2];
    bit     m_tmo   [2];
    bit     m_ms    [2];
    logic [6:0]  e_ctrl [2];
    logic [87:0] expv;
    stim_t       cur;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of inputs and derive the expected outputs for it.
    task automatic apply(input stim_t s);
        bit lu;
        rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_use1 = s.use1; id_use2 = s.use2;
        id_store = s.store; id_jump = s.jump; ex_dst = s.dst; ex_regwr = s.regwr;
        ex_memrd = s.memrd; ex_br = s.br; mem_req = s.req; mem_rdy = s.rdy;
        cur = s;
        // EX load targets a real register that ID needs as an early operand.
        lu = s.memrd && s.regwr && (s.dst != 0) &&
             ((s.use1 && s.rs == s.dst) || (s.use2 && !s.store && s.rt == s.dst));
        for (int k = 0; k < 2; k++) begin
            m_tmo[k] = (m_wait[k] == tmo_lim[k] - 1);
            m_ms[k]  = s.req && !s.rdy && !m_tmo[k];
            if (s.rst)        e_ctrl[k] = 7'b1111111;
            else if (m_ms[k]) e_ctrl[k] = C_FROZEN;
            else if (s.br)    e_ctrl[k] = 7'b1111110;
            else if (lu)      e_ctrl[k] = 7'b0001110;
            else if (s.jump)  e_ctrl[k] = C_JUMP;
            else              e_ctrl[k] = C_IDLE;
        end
        expv = {e_ctrl[0], m_err[0], m_stall[0][31:0], m_flush[0][31:0],
                e_ctrl[1], m_err[1], m_stall[1][3:0], m_flush[1][3:0]};
        #1;
    endtask

    // Advance through the active edge and update the model.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cur.rst) begin
                m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (!e_ctrl[k][6] && m_stall[k] < cnt_max[k]) m_stall[k]++;
                if (e_ctrl[k][4] && m_flush[k] < cnt_max[k]) m_flush[k]++;
                if (m_tmo[k] && !cur.rdy) m_err[k] = 1;
                m_wait[k] = m_ms[k] ? m_wait[k] + 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s);
        tick();
    endtask

    function automatic stim_t lw_dep(input logic [4:0] dst, input logic [4:0] rs);
        stim_t s;
        s = idle();
        s.memrd = 1; s.regwr = 1; s.dst = dst; s.use1 = 1; s.rs = rs;
        return s;
    endfunction

    task automatic test_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s);
        n_tests++;
        if (ctrl0 !== 7'b1111111) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 1111111", ctrl0);
        end
        tick();
        apply(idle());
        n_tests++;
        if (ctrl0 !== C_IDLE || stall0 !== 0 || flush0 !== 0 || err0 !== 0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%b stall=%0d flush=%0d err=%b want %b 0 0 0",
                     ctrl0, stall0, flush0, err0, C_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        apply(lw_dep(5'd8, 5'd8));
        n_tests++;
        if (pc_en0 !== 0 || ifid_en0 !== 0 || idex_fl0 !== 1) begin
            n_fail++;
            $display("FAIL lu_rs: pc_en=%b ifid_en=%b idex_flush=%b want 0 0 1", pc_en0, ifid_en0, idex_fl0);
        end
        tick();
        apply(idle());
        n_tests++;
        if (stall0 !== 32'd1 || pc_en0 !== 1) begin
            n_fail++; $display("FAIL lu_count: stall=%0d pc_en=%b want 1 1", stall0, pc_en0);
        end
        tick();
        apply(lw_dep(5'd0, 5'd0));
        n_tests++;
        if (ctrl0 !== C_IDLE) begin
            n_fail++; $display("FAIL lu_r0: ctrl=%b want %b", ctrl0, C_IDLE);
        end
        tick();
    endtask

    task automatic test_store_rt();
        stim_t s;
        do_reset();
        s = lw_dep(5'd8, 5'd3);
        s.use2 = 1; s.store = 1; s.rt = 5'd8;
        apply(s);
        n_tests++;
        if (pc_en0 !== 1) begin
            n_fail++; $display("FAIL store_rt: pc_en=%b want 1", pc_en0);
        end
        tick();
        s.rs = 5'd8;
        apply(s);
        n_tests++;
        if (pc_en0 !== 0 || idex_fl0 !== 1) begin
            n_fail++; $display("FAIL store_rs: pc_en=%b idex_flush=%b want 0 1", pc_en0, idex_fl0);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        stim_t s;
        do_reset();
        s = lw_dep(5'd8, 5'd8);
        s.jump = 1; s.br = 1;
        apply(s);
        n_tests++;
        if (ifid_fl0 !== 1 || idex_fl0 !== 1 || pc_en0 !== 1) begin
            n_fail++;
            $display("FAIL br_prio: ifid_flush=%b idex_flush=%b pc_en=%b want 1 1 1", ifid_fl0, idex_fl0, pc_en0);
        end
        tick();
        s = idle();
        s.jump = 1;
        apply(s);
        n_tests++;
        if (flush0 !== 32'd1 || ctrl0 !== C_JUMP) begin
            n_fail++; $display("FAIL jump_only: flush=%0d ctrl=%b want 1 %b", flush0, ctrl0, C_JUMP);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        stim_t s;
        do_reset();
        s = idle();
        s.req = 1; s.br = 1;
        for (int i = 0; i < 3; i++) begin
            apply(s);
            n_tests++;
            if (ctrl0 !== C_FROZEN || ctrl1 !== C_FROZEN) begin
                n_fail++; $display("FAIL mw_frozen%0d: ctrl=%b/%b want %b", i, ctrl0, ctrl1, C_FROZEN);
            end
            tick();
        end
        s.rdy = 1;
        apply(s);
        n_tests++;
        if (ctrl0 !== 7'b1111110) begin
            n_fail++; $display("FAIL mw_release: ctrl=%b want 1111110", ctrl0);
        end
        tick();
        apply(idle());
        n_tests++;
        if (stall0 !== 32'd3 || err0 !== 0 || err1 !== 0) begin
            n_fail++; $display("FAIL mw_count: stall=%0d err=%b/%b want 3 0/0", stall0, err0, err1);
        end
        tick();
    endtask

    task automatic test_timeout();
        stim_t s;
        do_reset();
        s = idle();
        s.req = 1;
        for (int i = 0; i < 4; i++) begin
            apply(s);
            n_tests++;
            if (ctrl1 !== (i < 3 ? C_FROZEN : C_IDLE) || ctrl0 !== C_FROZEN) begin
                n_fail++; $display("FAIL tmo_cyc%0d: ctrl_small=%b ctrl_dflt=%b", i, ctrl1, ctrl0);
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            s = idle();
            s.req = 1'($urandom_range(0, 1));
            s.rdy = 1;
            s.jump = 1'($urandom_range(0, 1));
            apply(s);
            n_tests++;
            if (err1 !== 1 || err0 !== 0) begin
                n_fail++; $display("FAIL tmo_sticky%0d: err_small=%b err_dflt=%b want 1 0", i, err1, err0);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(lw_dep(5'd5, 5'd5));
            tick();
        end
        apply(idle());
        n_tests++;
        if (stall1 !== 4'hF || stall0 !== 32'd20) begin
            n_fail++; $display("FAIL saturate: small=%0d dflt=%0d want 15 20", stall1, stall0);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        stim_t s;
        do_reset();
        s = idle();
        s.req = 1;
        for (int i = 0; i < 6; i++) begin
            apply(s);
            tick();
        end
        s.rst = 1;
        apply(s);
        n_tests++;
        if (ctrl0 !== 7'b1111111 || ctrl1 !== 7'b1111111) begin
            n_fail++; $display("FAIL rst_wait_ctrl: ctrl=%b/%b want 1111111", ctrl0, ctrl1);
        end
        tick();
        apply(idle());
        n_tests++;
        if (stall0 !== 0 || stall1 !== 0 || err1 !== 0 || ctrl0 !== C_IDLE || ctrl1 !== C_IDLE) begin
            n_fail++;
            $display("FAIL rst_wait_state: stall=%0d/%0d err_small=%b ctrl=%b/%b", stall0, stall1, err1, ctrl0, ctrl1);
        end
        tick();
    endtask

    task automatic test_random();
        stim_t s;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.dst   = 5'($urandom_range(0, 3));
            s.use1  = 1'($urandom_range(0, 1));
            s.use2  = 1'($urandom_range(0, 1));
            s.store = 1'($urandom_range(0, 1));
            s.jump  = ($urandom_range(0, 3) == 0);
            s.regwr = 1'($urandom_range(0, 1));
            s.memrd = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 4) == 0);
            s.req   = ($urandom_range(0, 2) != 0);
            s.rdy   = ($urandom_range(0, 5) == 0);
            apply(s);
            n_tests++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random%0d: got %h want %h", i, obs, expv);
            end
            tick();
        end
    endtask

    initial begin
        apply(idle());
        @(negedge clk);
        do_reset();
        test_reset();
        test_load_use();
        test_store_rt();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
